// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak state-path front end.
package keccak_pkg;

  localparam int NUM_LANES      = 25;
  localparam int LANE_W_DEFAULT = 64;
  localparam int LANE_NUM_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/keccak_lane_loader_if.sv
// Control, serial-input and lane-output bundle of the lane loader.
// master drives start/abort/serial bits/lane_ready; slave is the loader itself.
interface keccak_lane_loader_if #(
  parameter int LANE_W = keccak_pkg::LANE_W_DEFAULT
);
  import keccak_pkg::*;

  logic                  start;
  logic                  abort;
  logic                  in_valid;
  logic                  in_bit;
  logic                  in_ready;
  logic                  lane_valid;
  logic                  lane_ready;
  logic [LANE_NUM_W-1:0] lane_num;
  logic [LANE_W-1:0]     lane_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, in_valid, in_bit, lane_ready,
    input  in_ready, lane_valid, lane_num, lane_data, busy, done
  );

  modport slave (
    input  start, abort, in_valid, in_bit, lane_ready,
    output in_ready, lane_valid, lane_num, lane_data, busy, done
  );

endinterface

// File: rtl/keccak_lane_shift_reg.sv
// LANE_W-bit serial-in shift register with load enable.
// KECCAK_LANE_LOADER_MSB_FIRST_EN selects left shift (first bit lands in the MSB).
module keccak_lane_shift_reg #(
  parameter int LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              in_bit,
  output logic [LANE_W-1:0] data
);

  generate
    if (LANE_W == 1) begin : g_single
      // Single-bit lane simply captures the accepted bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data <= 1'b0;
        end else if (shift_en) begin
          data <= in_bit;
        end else begin
          data <= data;
        end
      end
    end else begin : g_multi
      // Shift the accepted bit in; data is held whenever shift_en is low
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data <= {LANE_W{1'b0}};
        end else if (shift_en) begin
`ifdef KECCAK_LANE_LOADER_MSB_FIRST_EN
          data <= {data[LANE_W-2:0], in_bit};
`else
          data <= {in_bit, data[LANE_W-1:1]};
`endif
        end else begin
          data <= data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/keccak_lane_loader.sv
// Serial-to-lane loader: assembles 25 lanes from a 1600-bit serial stream.
// Bit order is set in keccak_lane_shift_reg by KECCAK_LANE_LOADER_MSB_FIRST_EN.
module keccak_lane_loader #(
  parameter int LANE_W = keccak_pkg::LANE_W_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  keccak_lane_loader_if.slave bus
);
  import keccak_pkg::*;

  localparam logic [5:0]            LAST_BIT  = 6'(LANE_W - 1);
  localparam logic [LANE_NUM_W-1:0] LAST_LANE = LANE_NUM_W'(NUM_LANES - 1);
  localparam logic [LANE_NUM_W-1:0] LANE_ZERO = {LANE_NUM_W{1'b0}};
  localparam logic [LANE_NUM_W-1:0] LANE_ONE  = {{(LANE_NUM_W-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [5:0]            bit_cnt_r;
  logic [LANE_NUM_W-1:0] lane_num_r;
  logic                  in_ready_r;
  logic                  lane_valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  shift_en_s;
  logic [LANE_W-1:0]     lane_data_s;

  // abort must also block the shift so an aborted cycle stores nothing
  assign shift_en_s = (state_r == SHIFT) && bus.in_valid && !bus.abort;

  keccak_lane_shift_reg #(.LANE_W(LANE_W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en_s),
    .in_bit   (bus.in_bit),
    .data     (lane_data_s)
  );

  // Load sequencing FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 6'd0;
      lane_num_r   <= LANE_ZERO;
      in_ready_r   <= 1'b0;
      lane_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (bus.abort) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 6'd0;
      lane_num_r   <= LANE_ZERO;
      in_ready_r   <= 1'b0;
      lane_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r    <= SHIFT;
            bit_cnt_r  <= 6'd0;
            lane_num_r <= LANE_ZERO;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.in_valid) begin
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r    <= 6'd0;
              state_r      <= PRESENT;
              in_ready_r   <= 1'b0;
              lane_valid_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 6'd1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        PRESENT: begin
          if (bus.lane_ready) begin
            lane_valid_r <= 1'b0;
            if (lane_num_r == LAST_LANE) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              lane_num_r <= lane_num_r + LANE_ONE;
              state_r    <= SHIFT;
              in_ready_r <= 1'b1;
            end
          end else begin
            lane_valid_r <= 1'b1;
          end
        end
        DONE: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          lane_num_r <= LANE_ZERO;
          state_r    <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          bit_cnt_r    <= 6'd0;
          lane_num_r   <= LANE_ZERO;
          in_ready_r   <= 1'b0;
          lane_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.lane_valid = lane_valid_r;
  assign bus.lane_num   = lane_num_r;
  assign bus.lane_data  = lane_data_s;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule
